// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one shift-per-clock double-dabble engine among
// the X/Y/Z axis requesters; results go out on a tagged strobe bus and per-channel holds.
module bcd_conv_scheduler #(
  parameter int N_CH  = 3,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req,
  input  logic [WIDTH-1:0]     data_x,
  input  logic [WIDTH-1:0]     data_y,
  input  logic [WIDTH-1:0]     data_z,
  output logic [N_CH-1:0]      ack,
  output logic                 busy,
  output logic                 bcd_valid,
  output logic [1:0]           bcd_ch,
  output logic [3:0]           hundreds,
  output logic [3:0]           tens,
  output logic [3:0]           ones,
  output logic [12*N_CH-1:0]   bcd_all
);

  localparam int SW = WIDTH + 12;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
  function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] v);
    logic [SW-1:0] a;
    a = v;
    if (a[11:8] >= 4'd5) begin
      a[11:8] = a[11:8] + 4'd3;
    end
    if (a[15:12] >= 4'd5) begin
      a[15:12] = a[15:12] + 4'd3;
    end
    if (a[19:16] >= 4'd5) begin
      a[19:16] = a[19:16] + 4'd3;
    end
    return {a[SW-2:0], 1'b0};
  endfunction

  // Round-robin pick starting after the last grant: ptr+1, ptr+2, then ptr.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] o0;
    logic [1:0] o1;
    logic [1:0] o2;
    logic [1:0] w;
    case (p)
      2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (r[o0]) begin
      w = o0;
    end else if (r[o1]) begin
      w = o1;
    end else begin
      w = o2;
    end
    return w;
  endfunction

  state_t             state_r, state_s;
  logic [1:0]         ptr_r, ptr_s;
  logic [SW-1:0]      shift_r, shift_s;
  logic [2:0]         cnt_r, cnt_s;
  logic [N_CH-1:0]    ack_r, ack_s;
  logic               busy_r, busy_s;
  logic               valid_r, valid_s;
  logic [1:0]         ch_r, ch_s;
  logic [3:0]         hun_r, hun_s;
  logic [3:0]         ten_r, ten_s;
  logic [3:0]         one_r, one_s;
  logic [12*N_CH-1:0] all_r, all_s;

  logic [1:0]         win_s;
  logic [WIDTH-1:0]   data_sel_s;
  logic [SW-1:0]      step_s;

  assign win_s  = pick(req, ptr_r);
  assign step_s = dabble_step(shift_r);

  // Operand mux for the granted channel.
  always_comb begin
    data_sel_s = data_z;
    case (win_s)
      2'd0:    data_sel_s = data_x;
      2'd1:    data_sel_s = data_y;
      default: data_sel_s = data_z;
    endcase
  end

  // Next-state and next-output logic for the IDLE/SHIFT controller.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    ack_s   = 3'b000;
    busy_s  = busy_r;
    valid_s = 1'b0;
    ch_s    = ch_r;
    hun_s   = hun_r;
    ten_s   = ten_r;
    one_s   = one_r;
    all_s   = all_r;
    case (state_r)
      IDLE: begin
        if (req != 3'b000) begin
          shift_s = {12'd0, data_sel_s};
          ptr_s   = win_s;
          ch_s    = win_s;
          ack_s   = 3'b001 << win_s;
          busy_s  = 1'b1;
          cnt_s   = 3'd0;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        shift_s = step_s;
        cnt_s   = cnt_r + 3'd1;
        if (cnt_r == 3'd7) begin
          hun_s   = step_s[19:16];
          ten_s   = step_s[15:12];
          one_s   = step_s[11:8];
          valid_s = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
          case (ch_r)
            2'd0:    all_s[11:0]  = step_s[19:8];
            2'd1:    all_s[23:12] = step_s[19:8];
            2'd2:    all_s[35:24] = step_s[19:8];
            default: all_s        = all_r;
          endcase
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; the last-grant pointer resets to 2 so channel 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 2'd2;
      shift_r <= 20'd0;
      cnt_r   <= 3'd0;
      ack_r   <= 3'b000;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      ch_r    <= 2'd0;
      hun_r   <= 4'd0;
      ten_r   <= 4'd0;
      one_r   <= 4'd0;
      all_r   <= 36'd0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      shift_r <= shift_s;
      cnt_r   <= cnt_s;
      ack_r   <= ack_s;
      busy_r  <= busy_s;
      valid_r <= valid_s;
      ch_r    <= ch_s;
      hun_r   <= hun_s;
      ten_r   <= ten_s;
      one_r   <= one_s;
      all_r   <= all_s;
    end
  end

  assign ack       = ack_r;
  assign busy      = busy_r;
  assign bcd_valid = valid_r;
  assign bcd_ch    = ch_r;
  assign hundreds  = hun_r;
  assign tens      = ten_r;
  assign ones      = one_r;
  assign bcd_all   = all_r;

endmodule
